// File: rtl/ysyx_25040129_skid_buffer.sv
// Two-entry valid/ready skid buffer: registers both in_ready and out_valid so the
// backward ready path between pipeline stages is cut, while keeping full throughput.
module ysyx_25040129_skid_buffer #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipeline_flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_fire;
    logic                  out_fire;

    // Handshake outputs decode only the state register, never the live inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            EMPTY: begin
                in_ready  = 1'b1;
                occupancy = 2'd0;
            end
            BUSY: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (pipeline_flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: the extra beat lands in skid.
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: doc/ysyx_25040129_skid_buffer.md
# ysyx_25040129_skid_buffer

Two-entry valid/ready skid buffer placed between NPC pipeline stages wherever the backward `ready` path must be cut. It decouples `in_ready` from `out_ready` combinationally: both `in_ready` and `out_valid` are driven straight from state flops. It sustains one transfer per cycle with strict FIFO order. A synchronous `pipeline_flush` discards all buffered data.

## Interface
- `DATA_WIDTH`, default 128: payload width in bits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pipeline_flush`  in  1  synchronous flush; empties the buffer.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  buffer can accept this cycle; a function of state only.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `out_valid`  out  1  `main` entry holds valid data.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_WIDTH  contents of the `main` register.
- `occupancy`  out  2  number of buffered entries (0, 1 or 2).

## Operation
- Storage is two registers, `main` and `skid`. `out_data` is always `main`.
- Handshake events:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
- States:
  - EMPTY (occupancy 0): `in_ready`=1, `out_valid`=0.
  - BUSY (occupancy 1): `in_ready`=1, `out_valid`=1.
  - FULL (occupancy 2): `in_ready`=0, `out_valid`=1.
- Transitions from EMPTY:
  - in_fire → BUSY, `main` <= `in_data`.
  - otherwise hold.
- Transitions from BUSY:
  - in_fire & out_fire → BUSY, `main` <= `in_data`.
  - in_fire & !out_ready → FULL, `skid` <= `in_data`.
  - !in_fire & out_fire → EMPTY.
  - otherwise hold.
- Transitions from FULL:
  - out_ready → BUSY, `main` <= `skid`.
  - otherwise hold. No input is accepted because `in_ready`=0.
- Unreachable state encoding → EMPTY.
- `in_valid` while `in_ready`=0 is ignored. `in_data` is not sampled.
- Data is never reordered, duplicated or dropped, except on flush or reset.
- `main` and `skid` hold their values when not being written. No X is propagated from unused `in_data`.

## Timing
- Reset (asynchronous, takes effect immediately, independent of `clk`):
  - state EMPTY.
  - `main`, `skid` = 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `occupancy`=0.
- Reset during any state or a handshake aborts it. No transfer completes in that cycle.
- Flush (synchronous, sampled at the rising edge):
  - Next state EMPTY; `main`, `skid` cleared to 0.
  - Overrides any simultaneous in_fire or out_fire. Data offered in the flush cycle is discarded.
  - An out_fire in the flush cycle is still a completed transfer from the consumer's view; the buffer simply does not advance further.
- Latency: a payload accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N (one cycle). This holds only if the buffer was EMPTY, or if BUSY with a simultaneous out_fire.
- Throughput: one transfer per cycle in steady state, with `out_ready` held at 1.
- Backpressure propagation:
  - `out_ready` dropping at edge N causes `in_ready` to fall after edge N, only if an in_fire occurred at N.
  - At most one extra beat is absorbed, into `skid`.
- Recovery: from FULL, `out_ready`=1 at edge N → BUSY after N. `in_ready`=1 from that cycle on.
- No combinational path from `out_ready` to `in_ready`, nor from `in_valid` to `out_valid`.
- `occupancy` updates on the same edge as the state.

## Test plan
- Reset/idle: assert `rst` mid-cycle with the buffer FULL.
  - Immediately (before the next edge): `out_valid`=0, `in_ready`=1, `out_data`=0, `occupancy`=0.
- Streaming: `out_ready`=1, push 0x1,0x2,0x3 on consecutive cycles.
  - `out_data` shows 0x1,0x2,0x3 on the following consecutive cycles.
  - `in_ready` stays 1 and `occupancy` stays 1.
- Skid fill: push 0xA, then 0xB with `out_ready`=0.
  - After the second edge: state FULL, `in_ready`=0, `occupancy`=2, `out_data`=0xA.
  - A third push of 0xC is ignored.
- Drain: from the previous end state, raise `out_ready` for 2 cycles.
  - Outputs 0xA then 0xB; 0xC is never output.
  - Then `occupancy`=0, `out_valid`=0.
- Simultaneous in/out in BUSY: `main`=0x5, `out_ready`=1, push 0x6.
  - Next cycle `out_data`=0x6, `occupancy`=1.
- Flush: in FULL, assert `pipeline_flush` together with `in_valid` (0x9) and `out_ready`=1.
  - Next cycle EMPTY, `out_data`=0, `occupancy`=0.
  - 0x9 never appears on the output.
